// File: rtl/spi_stream_pkg.sv
// spi_stream_pkg
// Shared definitions for the streaming SPI slave:
//   - bit positions inside the sticky err_flags vector
//   - FSM state encoding
//   - helper that derives which SCLK edge samples MOSI from CPOL/CPHA
package spi_stream_pkg;

    localparam int ERR_RX_OVF = 0;
    localparam int ERR_TX_UNF = 1;
    localparam int ERR_ABORT  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // Leading edge is rising when CPOL=0 and falling when CPOL=1.
    // CPHA=0 samples on the leading edge and CPHA=1 on the trailing edge.
    // Together, sampling happens on the rising edge exactly when CPOL == CPHA.
    function automatic logic sample_on_rising(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Registered first-word-fall-through FIFO. The head entry is always visible
// on pop_data. A push into an empty FIFO becomes visible on the next clock;
// nothing bypasses the storage.
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   push, push_data      write request and data (ignored when full unless popping)
//   full                 no free entry
//   pop, pop_data        read request (ignored when empty) and head data
//   empty                no stored entry
//   level                occupancy, updated the cycle after a handshake
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // A pop frees the slot the simultaneous push lands in, so push is still
    // accepted when full. Popping an empty FIFO does nothing.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/spi_slave_stream.sv
// spi_slave_stream
// SPI slave that oversamples SCLK/MOSI/SS_n in the clk domain and streams
// whole words through RX and TX FIFOs with valid/ready handshakes.
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   spi_sclk, spi_mosi, spi_ss_n SPI inputs from the controller (asynchronous)
//   spi_miso, spi_miso_oe        slave data out and its enable (high while selected)
//   rx_data, rx_valid, rx_ready  received word stream
//   tx_data, tx_valid, tx_ready  words to transmit
//   rx_level, tx_level           FIFO occupancies
//   err_flags, err_clr           sticky {frame_abort, tx_underflow, rx_overflow}, clear
module spi_slave_stream
    import spi_stream_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                FIFO_DEPTH  = 16,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_FILL     = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          spi_sclk,
    input  logic                          spi_mosi,
    input  logic                          spi_ss_n,
    output logic                          spi_miso,
    output logic                          spi_miso_oe,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [2:0]                    err_flags,
    input  logic                          err_clr
);

    localparam bit                SAMPLE_RISE = sample_on_rising(CPOL, CPHA);
    localparam int                CNT_W       = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_s, sclk_q, mosi_s, ss_s, ss_q;
    logic                   sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic                   ss_fall, ss_rise;

    spi_state_t             state, next_state;
    logic                   active;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_shift, rx_next, rx_word;
    logic                   rx_push;
    logic [DATA_W-1:0]      tx_shift, tx_shifted, tx_fifo_data;
    logic                   tx_load, abort;
    logic                   rx_full, rx_empty, tx_full, tx_empty;
    logic [2:0]             err_set;

    // Synchronisers reset to the idle bus levels so no spurious edge or
    // select is seen when reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_q    <= CPOL;
            ss_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sclk_q    <= sclk_s;
            ss_q      <= ss_s;
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_q;
    assign sclk_fall   = ~sclk_s & sclk_q;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign ss_fall     = ss_q & ~ss_s;
    assign ss_rise     = ~ss_q & ss_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ss_fall) next_state = ACTIVE;
            ACTIVE:  if (ss_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        active      = (state == ACTIVE);
        spi_miso_oe = active;
    end

    // With CPHA=0 the first bit must be on MISO before the first edge, so
    // the word is loaded on select; otherwise it is loaded by the shift edge
    // that starts each word.
    assign tx_load = (!CPHA && (state == IDLE) && ss_fall) ||
                     (active && shift_edge && (bit_cnt == '0));
    assign abort   = active && ss_rise && (bit_cnt != '0);

    assign tx_shifted = MSB_FIRST ? {tx_shift[DATA_W-2:0], 1'b0}
                                  : {1'b0, tx_shift[DATA_W-1:1]};
    assign rx_next    = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s}
                                  : {mosi_s, rx_shift[DATA_W-1:1]};
    assign spi_miso   = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];

    always_comb begin
        err_set             = '0;
        err_set[ERR_RX_OVF] = rx_push && rx_full && !rx_ready;
        err_set[ERR_TX_UNF] = tx_load && tx_empty;
        err_set[ERR_ABORT]  = abort;
    end

    // A completed word is held in rx_word and pushed one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_word   <= '0;
            rx_push   <= 1'b0;
            tx_shift  <= '0;
            err_flags <= '0;
        end else begin
            rx_push <= 1'b0;
            if (tx_load) begin
                tx_shift <= tx_empty ? TX_FILL : tx_fifo_data;
            end else if (active && shift_edge) begin
                tx_shift <= tx_shifted;
            end
            if (abort) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (active && sample_edge) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    rx_word <= rx_next;
                    rx_push <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            err_flags <= (err_flags & ~{3{err_clr}}) | err_set;
        end
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rx_push),
        .push_data (rx_word),
        .full      (rx_full),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .full      (tx_full),
        .pop       (tx_load),
        .pop_data  (tx_fifo_data),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    assign rx_valid = !rx_empty;
    assign tx_ready = !tx_full;

endmodule

// File: tb/tb_spi_slave_stream.sv
// tb_spi_slave_stream
// Bench for spi_slave_stream. Device 0 is mode 0, 8-bit, MSB first,
// TX_FILL=0xFF. Devices 1..3 are 16-bit LSB-first in modes (0,1), (1,0), (1,1).
// SCLK and MOSI are shared; each device has its own SS_n and MISO.
// Expected RX words and expected MISO words are queued when stimulus is
// applied and compared as the DUT or the bus produces them.
module tb_spi_slave_stream;

    localparam int HP = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sclk, mosi;
    logic [3:0]  ss_n, miso, miso_oe;
    logic [15:0] tx_data;
    logic [3:0]  tx_valid;
    logic        rx_ready, err_clr;

    logic [7:0]  rx_data0;
    logic        rx_valid0, tx_ready0;
    logic [4:0]  rx_level0, tx_level0;
    logic [2:0]  err0;

    logic [15:0] rx_data_s  [3];
    logic [2:0]  rx_valid_s, tx_ready_s;
    logic [4:0]  rx_level_s [3];
    logic [4:0]  tx_level_s [3];
    logic [2:0]  err_s      [3];

    logic [1:0]  cur_dev;
    logic        cur_rx_valid, cur_tx_ready, cur_miso;
    logic [31:0] cur_rx_data;
    logic [4:0]  cur_rx_level, cur_tx_level;
    logic [2:0]  cur_err;

    logic [31:0] mosi_buf [0:19];
    logic [31:0] rx_exp[$];
    logic [31:0] miso_exp[$];
    int          checks = 0;
    int          errors = 0;
    int          rx_unexpected = 0;

    always #5 clk = ~clk;

    spi_slave_stream #(
        .DATA_W(8), .FIFO_DEPTH(16), .CPOL(1'b0), .CPHA(1'b0),
        .MSB_FIRST(1'b1), .SYNC_STAGES(2), .TX_FILL(8'hFF)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss_n[0]),
        .spi_miso(miso[0]), .spi_miso_oe(miso_oe[0]),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
        .tx_data(tx_data[7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready0),
        .rx_level(rx_level0), .tx_level(tx_level0),
        .err_flags(err0), .err_clr(err_clr)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        spi_slave_stream #(
            .DATA_W(16), .FIFO_DEPTH(16), .CPOL(g != 0), .CPHA(g != 1),
            .MSB_FIRST(1'b0), .SYNC_STAGES(2), .TX_FILL(16'h0000)
        ) u_dut_m (
            .clk(clk), .reset_n(reset_n),
            .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss_n[g+1]),
            .spi_miso(miso[g+1]), .spi_miso_oe(miso_oe[g+1]),
            .rx_data(rx_data_s[g]), .rx_valid(rx_valid_s[g]), .rx_ready(rx_ready),
            .tx_data(tx_data), .tx_valid(tx_valid[g+1]), .tx_ready(tx_ready_s[g]),
            .rx_level(rx_level_s[g]), .tx_level(tx_level_s[g]),
            .err_flags(err_s[g]), .err_clr(err_clr)
        );
    end

    always_comb begin
        cur_miso     = miso[cur_dev];
        cur_rx_valid = rx_valid0;
        cur_rx_data  = {24'h0, rx_data0};
        cur_tx_ready = tx_ready0;
        cur_rx_level = rx_level0;
        cur_tx_level = tx_level0;
        cur_err      = err0;
        if (cur_dev != 2'd0) begin
            cur_rx_valid = rx_valid_s[cur_dev - 2'd1];
            cur_rx_data  = {16'h0, rx_data_s[cur_dev - 2'd1]};
            cur_tx_ready = tx_ready_s[cur_dev - 2'd1];
            cur_rx_level = rx_level_s[cur_dev - 2'd1];
            cur_tx_level = tx_level_s[cur_dev - 2'd1];
            cur_err      = err_s[cur_dev - 2'd1];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // RX scoreboard: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && cur_rx_valid && rx_ready) begin
            if (rx_exp.size() > 0) checkOutput("rx_data", cur_rx_data, rx_exp.pop_front());
            else rx_unexpected++;
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Push one word into the selected device's TX FIFO.
    task automatic applyStimulus(input logic [1:0] dev, input logic [15:0] word);
        int n = 0;
        cur_dev       = dev;
        tx_data       = word;
        tx_valid[dev] = 1'b1;
        while (!cur_tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid[dev] = 1'b0;
        if (n >= 50) checkOutput("tx_ready_timeout", n, 0);
    endtask

    // Controller side of one frame. stop_bits > 0 raises SS after that many bits.
    task automatic spiFrame(input logic [1:0] dev, input int width, input bit cpol,
                            input bit cpha, input bit msb, input int nwords,
                            input int stop_bits, input bit measure);
        int          total;
        int          wi, bi, pos, lat;
        bit          seen;
        logic [31:0] mw, sw, exp;
        total   = (stop_bits > 0) ? stop_bits : nwords * width;
        cur_dev = dev;
        seen    = 1'b0;
        lat     = 0;
        sw      = '0;
        sclk    = cpol;
        waitClk(HP);
        ss_n[dev] = 1'b0;
        waitClk(HP);
        for (int b = 0; b < total; b++) begin
            wi  = b / width;
            bi  = b % width;
            pos = msb ? (width - 1 - bi) : bi;
            mw  = mosi_buf[wi];
            if (bi == 0) sw = '0;
            if (!cpha) begin
                mosi = mw[pos];
                waitClk(HP);
                sclk = ~cpol;
                sw[pos] = cur_miso;
            end else begin
                sclk = ~cpol;
                mosi = mw[pos];
                waitClk(HP);
                sclk = cpol;
                sw[pos] = cur_miso;
            end
            for (int c = 1; c <= HP; c++) begin
                @(negedge clk);
                if (measure && b == total - 1 && !seen && cur_rx_valid) begin
                    seen = 1'b1;
                    lat  = c;
                end
            end
            if (!cpha) sclk = cpol;
            if (stop_bits == 0 && bi == width - 1) begin
                exp = (miso_exp.size() > 0) ? miso_exp.pop_front() : 'x;
                checkOutput("miso_word", sw, exp);
            end
        end
        waitClk(HP);
        ss_n[dev] = 1'b1;
        waitClk(2 * HP);
        if (measure) checkOutput("rx_latency_le5", {31'h0, seen && lat <= 5}, 1);
    endtask

    task automatic waitRxDrain();
        int n = 0;
        while (rx_exp.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        waitClk(3);
        checkOutput("rx_drain", rx_exp.size(), 0);
        checkOutput("rx_idle", {31'h0, cur_rx_valid}, 0);
        checkOutput("rx_unexpected", rx_unexpected, 0);
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        waitClk(1);
        err_clr = 1'b0;
        waitClk(1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic cp, ch;
        reset_n  = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        ss_n     = 4'hF;
        tx_data  = '0;
        tx_valid = '0;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        cur_dev  = 2'd0;
        #2;
        checkOutput("rst_miso",     {31'h0, miso[0]},    0);
        checkOutput("rst_miso_oe",  {28'h0, miso_oe},    0);
        checkOutput("rst_rx_valid", {31'h0, rx_valid0},  0);
        checkOutput("rst_rx_data",  {24'h0, rx_data0},   0);
        checkOutput("rst_tx_ready", {31'h0, tx_ready0},  1);
        checkOutput("rst_levels",   {22'h0, rx_level0, tx_level0}, 0);
        checkOutput("rst_err",      {29'h0, err0},       0);
        waitClk(4);
        reset_n = 1'b1;
        waitClk(4);

        // Mode 0 single word; an extra TX word covers the closing shift-edge load.
        applyStimulus(2'd0, 16'h00A5);
        applyStimulus(2'd0, 16'h0000);
        mosi_buf[0] = 32'h3C;
        miso_exp.push_back(32'hA5);
        rx_exp.push_back(32'h3C);
        spiFrame(2'd0, 8, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1);
        waitRxDrain();
        checkOutput("m0_err", {29'h0, cur_err}, 0);
        checkOutput("m0_tx_level", {27'h0, cur_tx_level}, 0);

        // Other modes, 16-bit LSB first.
        for (int g = 0; g < 3; g++) begin
            cp = (g != 0);
            ch = (g != 1);
            applyStimulus(2'(g + 1), 16'hBEEF);
            if (!ch) applyStimulus(2'(g + 1), 16'h0000);
            mosi_buf[0] = 32'h1234;
            miso_exp.push_back(32'hBEEF);
            rx_exp.push_back(32'h1234);
            spiFrame(2'(g + 1), 16, cp, ch, 1'b0, 1, 0, 1'b0);
            waitRxDrain();
            checkOutput($sformatf("mode%0d_err", g + 1), {29'h0, cur_err}, 0);
        end

        // RX overflow: 17 words into a 16-deep FIFO with the sink stalled.
        rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(2'd0, 16'(8'h40 + i));
            applyStimulus(2'd0, 16'h0000);
            mosi_buf[0] = 32'(8'h10 + i);
            miso_exp.push_back(32'(8'h40 + i));
            if (i < 16) rx_exp.push_back(32'(8'h10 + i));
            spiFrame(2'd0, 8, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        end
        checkOutput("ovf_rx_level", {27'h0, cur_rx_level}, 16);
        checkOutput("ovf_err", {29'h0, cur_err}, 32'h1);
        rx_ready = 1'b1;
        waitRxDrain();
        pulseErrClr();
        checkOutput("ovf_err_clr", {29'h0, cur_err}, 0);

        // TX underflow: empty TX FIFO sends TX_FILL for every word.
        mosi_buf[0] = 32'h5A;
        mosi_buf[1] = 32'hC3;
        miso_exp.push_back(32'hFF);
        miso_exp.push_back(32'hFF);
        rx_exp.push_back(32'h5A);
        rx_exp.push_back(32'hC3);
        spiFrame(2'd0, 8, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0);
        waitRxDrain();
        checkOutput("unf_err", {29'h0, cur_err}, 32'h2);
        pulseErrClr();
        checkOutput("unf_err_clr", {29'h0, cur_err}, 0);

        // Abort after 5 bits, then a clean frame.
        applyStimulus(2'd0, 16'h0077);
        mosi_buf[0] = 32'hB6;
        spiFrame(2'd0, 8, 1'b0, 1'b0, 1'b1, 1, 5, 1'b0);
        checkOutput("abort_err", {29'h0, cur_err}, 32'h4);
        checkOutput("abort_rx_level", {27'h0, cur_rx_level}, 0);
        checkOutput("abort_tx_level", {27'h0, cur_tx_level}, 0);
        checkOutput("abort_rx_unexpected", rx_unexpected, 0);
        pulseErrClr();
        applyStimulus(2'd0, 16'h0096);
        applyStimulus(2'd0, 16'h0000);
        mosi_buf[0] = 32'hE7;
        miso_exp.push_back(32'h96);
        rx_exp.push_back(32'hE7);
        spiFrame(2'd0, 8, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        waitRxDrain();
        checkOutput("post_abort_err", {29'h0, cur_err}, 0);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(2'd0, 16'h005B);
        applyStimulus(2'd0, 16'h0000);
        cur_dev = 2'd0;
        sclk    = 1'b0;
        waitClk(HP);
        ss_n[0] = 1'b0;
        waitClk(HP);
        for (int b = 0; b < 3; b++) begin
            mosi = 1'b1;
            waitClk(HP);
            sclk = 1'b1;
            waitClk(HP);
            sclk = 1'b0;
        end
        waitClk(HP);
        checkOutput("mid_oe", {31'h0, miso_oe[0]}, 1);
        checkOutput("mid_miso", {31'h0, miso[0]}, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("arst_miso",     {31'h0, miso[0]},    0);
        checkOutput("arst_miso_oe",  {31'h0, miso_oe[0]}, 0);
        checkOutput("arst_rx_valid", {31'h0, rx_valid0},  0);
        checkOutput("arst_rx_data",  {24'h0, rx_data0},   0);
        checkOutput("arst_tx_ready", {31'h0, tx_ready0},  1);
        checkOutput("arst_levels",   {22'h0, rx_level0, tx_level0}, 0);
        checkOutput("arst_err",      {29'h0, err0},       0);
        ss_n[0] = 1'b1;
        mosi    = 1'b0;
        waitClk(4);
        reset_n = 1'b1;
        waitClk(4);
        applyStimulus(2'd0, 16'h00C9);
        applyStimulus(2'd0, 16'h0000);
        mosi_buf[0] = 32'h69;
        miso_exp.push_back(32'hC9);
        rx_exp.push_back(32'h69);
        spiFrame(2'd0, 8, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        waitRxDrain();
        checkOutput("post_rst_err", {29'h0, cur_err}, 0);
        checkOutput("miso_exp_left", miso_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
